// File: rtl/toggle_window_monitor.sv
// Observes the parity sub-circuit output n_8 and reports, per window of 2**WIN_LOG2
// enabled samples, how often it switched and how often it was high.
module toggle_window_monitor #(
  parameter int WIN_LOG2 = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             n_8,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_toggles,
  output logic [CNT_W-1:0] rpt_ones,
  output logic             rpt_overrun
);

  if (CNT_W <= WIN_LOG2) begin : g_bad_cnt_w
    $error("toggle_window_monitor: CNT_W must be greater than WIN_LOG2");
  end
  if (WIN_LOG2 < 1) begin : g_bad_win
    $error("toggle_window_monitor: WIN_LOG2 must be at least 1");
  end

  typedef enum logic {PRIME, RUN} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] toggles;
    logic [CNT_W-1:0] ones;
  } rpt_t;

  state_t              state_q, state_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]    tog_q, tog_d, one_q, one_d;
  logic                prev_q, prev_d;
  logic                tog_bit, win_end, load;
  rpt_t                win_rpt, rpt_q;
  logic                rpt_valid_q, overrun_q;

  // First sample after reset has no predecessor, so it never counts as a toggle.
  assign tog_bit          = (state_q == RUN) & (n_8 ^ prev_q);
  assign win_rpt.toggles  = tog_q + CNT_W'(tog_bit);
  assign win_rpt.ones     = one_q + CNT_W'(n_8);
  // win_cnt all-ones means this sample is the last of the window.
  assign win_end          = sample_en & (&win_cnt_q);
  assign load             = win_end & (~rpt_valid_q | rpt_ready);

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    tog_d     = tog_q;
    one_d     = one_q;
    prev_d    = prev_q;
    if (sample_en) begin
      state_d   = RUN;
      prev_d    = n_8;
      win_cnt_d = win_cnt_q + 1'b1;
      if (win_end) begin
        tog_d = '0;
        one_d = '0;
      end else begin
        tog_d = win_rpt.toggles;
        one_d = win_rpt.ones;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PRIME;
      win_cnt_q <= '0;
      tog_q     <= '0;
      one_q     <= '0;
      prev_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      tog_q     <= tog_d;
      one_q     <= one_d;
      prev_q    <= prev_d;
    end
  end

  // Report register: a closing window while a report is stuck is dropped, not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q       <= '0;
      rpt_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (load) begin
        rpt_q       <= win_rpt;
        rpt_valid_q <= 1'b1;
      end else if (rpt_valid_q && rpt_ready) begin
        rpt_valid_q <= 1'b0;
      end
      if (win_end && rpt_valid_q && !rpt_ready)
        overrun_q <= 1'b1;
    end
  end

  assign rpt_valid   = rpt_valid_q;
  assign rpt_toggles = rpt_q.toggles;
  assign rpt_ones    = rpt_q.ones;
  assign rpt_overrun = overrun_q;

endmodule

// File: tb/tb_toggle_window_monitor.sv
// Scoreboard bench: a sample-list model predicts window reports; a negedge monitor
// compares and retires them as the consumer accepts.
module tb_toggle_window_monitor;
  localparam int WIN_LOG2 = 4;
  localparam int CNT_W    = 8;
  localparam int WIN      = 1 << WIN_LOG2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_en = 1'b0;
  logic             n_8 = 1'b0;
  logic             rpt_ready = 1'b0;
  logic             rpt_valid;
  logic [CNT_W-1:0] rpt_toggles;
  logic [CNT_W-1:0] rpt_ones;
  logic             rpt_overrun;

  toggle_window_monitor #(.WIN_LOG2(WIN_LOG2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .n_8(n_8), .rpt_ready(rpt_ready),
    .rpt_valid(rpt_valid), .rpt_toggles(rpt_toggles), .rpt_ones(rpt_ones),
    .rpt_overrun(rpt_overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int t; int o; } exp_t;

  exp_t exp_q[$];
  bit   win[$];
  bit   has_last, last, exp_ovr;
  exp_t r;
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect a window's samples, then count level changes against the
  // previous sample (carried across windows, forgotten at reset).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      win.delete();
      has_last = 1'b0;
      last     = 1'b0;
      exp_ovr  = 1'b0;
    end else if (sample_en) begin
      win.push_back(n_8);
      if (win.size() == WIN) begin
        r.t = 0;
        r.o = 0;
        foreach (win[i]) begin
          if (has_last && win[i] != last) r.t++;
          if (win[i]) r.o++;
          last     = win[i];
          has_last = 1'b1;
        end
        if (exp_q.size() == 0) exp_q.push_back(r);
        else exp_ovr = 1'b1;
        win.delete();
      end
    end
  end

  // Monitor: ready seen at negedge is the value the next edge acts on.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rpt_valid", int'(rpt_valid), int'(exp_q.size() != 0));
      chk("rpt_overrun", int'(rpt_overrun), int'(exp_ovr));
      if (rpt_valid && exp_q.size() != 0) begin
        chk("rpt_toggles", int'(rpt_toggles), exp_q[0].t);
        chk("rpt_ones", int'(rpt_ones), exp_q[0].o);
        if (rpt_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input bit se, input bit n, input bit rdy);
    sample_en = se;
    n_8       = n;
    rpt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(rpt_valid), 0);
    chk({tag, "_toggles"}, int'(rpt_toggles), 0);
    chk({tag, "_ones"}, int'(rpt_ones), 0);
    chk({tag, "_overrun"}, int'(rpt_overrun), 0);
  endtask

  bit g;

  initial begin
    rst = 1'b1;
    repeat (2) cyc(0, 0, 0);
    chk_zero("reset");
    rst = 1'b0;

    // toggle every cycle
    for (int i = 0; i < 64; i++) cyc(1, 1'(i % 2), 1);
    // constant high, then low from a window boundary
    repeat (32) cyc(1, 1, 1);
    repeat (16) cyc(1, 0, 1);
    // gapped sampling, value flips only while disabled
    g = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) cyc(1, g, 1);
      else begin
        g = ~g;
        cyc(0, g, 1);
      end
    end
    // backpressure long enough to overrun
    repeat (40) cyc(1, 1'($urandom), 0);
    repeat (8) cyc(1, 1'($urandom), 1);

    // fresh start, then accept on exactly the closing edge of the next window
    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
    repeat (16) cyc(1, 1'($urandom), 0);
    repeat (15) cyc(1, 1'($urandom), 0);
    cyc(1, 1'($urandom), 1);
    repeat (4) cyc(1, 1'($urandom), 1);

    // random mix
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0));

    // async reset mid-window, with a report possibly pending
    repeat (20) cyc(1, 1'($urandom), 0);
    repeat (7) cyc(1, 1'($urandom), 0);
    #3 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) cyc(1, 1'($urandom), 1);
    repeat (3) cyc(0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toggle_window_monitor.md
Name: toggle_window_monitor

Overview:
- Downstream observation stage for the 4-input parity/XOR sub-circuit in the power sub-circuit experiments.
- Samples that sub-circuit's single output net (n_8) on enabled cycles.
- Over fixed-length windows of enabled samples, counts output transitions (switching activity) and high samples (signal probability).
- Hands each window's result to a power-estimation consumer over a valid/ready interface.

Parameters:
- WIN_LOG2, 4, window length = 2**WIN_LOG2 enabled samples.
- CNT_W, 8, width of the report counters. Must be greater than WIN_LOG2; elaboration error otherwise.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sample_en  input  1  when 1, n_8 is sampled this cycle.
- n_8  input  1  observed output net of the upstream sub-circuit.
- rpt_ready  input  1  consumer accepts the report when high together with rpt_valid.
- rpt_valid  output  1  report register holds an unconsumed report.
- rpt_toggles  output  CNT_W  transitions counted in the reported window.
- rpt_ones  output  CNT_W  samples equal to 1 in the reported window.
- rpt_overrun  output  1  sticky; a completed window was dropped because the report register was full.

Behaviour:
- Reset (async, immediate): rpt_valid=0, rpt_toggles=0, rpt_ones=0, rpt_overrun=0. Internally: win_cnt=0, tog_acc=0, one_acc=0, prev=0, state=PRIME.
- Sampling FSM:
  - PRIME: waiting for the first sample after reset. On sample_en=1: prev<=n_8; one_acc+=n_8; no toggle counted; win_cnt<=1; go to RUN.
  - RUN: on sample_en=1: tog_acc+=(n_8^prev); one_acc+=n_8; prev<=n_8; win_cnt+=1.
  - Cycles with sample_en=0 change nothing. prev is held across gaps, so a toggle across a gap is counted once.
- Window end: the enabled sample that brings win_cnt to 2**WIN_LOG2 is included in the window's counts. On that same edge:
  - the final tog_acc/one_acc values (including this sample) are offered to the report register;
  - accumulators reset to 0;
  - win_cnt wraps to 0;
  - FSM stays in RUN; prev is never cleared, so the toggle at a window boundary belongs to the new window.
- No saturation: max count is 2**WIN_LOG2 <= 2**CNT_W - 1.
- Report register:
  - Loaded when a window ends and (rpt_valid==0, or rpt_valid&rpt_ready in the same cycle).
  - Load sets rpt_valid=1 on the next cycle.
  - Latency: report visible 1 cycle after the closing sample edge.
  - rpt_valid & rpt_ready with no simultaneous window end: rpt_valid<=0.
  - Simultaneous accept and window end: new report loaded; rpt_valid stays 1; no overrun.
  - Window end while rpt_valid=1 and rpt_ready=0: new report dropped; old report held unchanged; rpt_overrun<=1.
  - rpt_overrun stays 1 until rst.
  - rpt_toggles/rpt_ones stay stable while rpt_valid=1 and not accepted.
- Reset mid-window: partial counts are discarded, FSM returns to PRIME, and any pending report is lost.
- Estimated RTL size: about 150 lines.

Test Plan:
- Toggle every cycle: rst pulse; sample_en=1 constant; n_8 = 0,1,0,1,...; rpt_ready=1. First report: rpt_toggles=15, rpt_ones=8 (PRIME sample not toggled). Every later report: rpt_toggles=16, rpt_ones=8. rpt_valid is 1-cycle pulses every 16 cycles; rpt_overrun=0.
- Constant high: n_8=1, sample_en=1. Reports: toggles=0, ones=16. Then switch n_8 to 0 at a window boundary → next report toggles=1, ones=0.
- Gapped sampling: sample_en alternates 1/0; n_8 changes only on disabled cycles, so each enabled sample differs from the last. First report arrives after 32 cycles with toggles=15.
- Backpressure: rpt_ready=0 for 40 cycles. First report held stable and unchanged; second window end sets rpt_overrun=1. Raise rpt_ready → report accepted; rpt_valid drops; rpt_overrun stays 1.
- Simultaneous accept and window end: rpt_ready asserted on the cycle a window closes with a report pending. rpt_valid stays 1, new counts appear next cycle, rpt_overrun=0.
- Async reset mid-window: assert rst after 7 samples, asynchronous to clk. All outputs drop to 0 immediately; after release, the next report covers a fresh 16 samples, with the first sample not counted as a toggle.
